ddr4_ca_cmd_driver: RTL

- Controller-side stage directly upstream of the DDR4 pin interface bundle.
- Accepts abstract DRAM commands over a valid/ready handshake.
- Encodes each command onto the DDR4 command/address pins with registered outputs and inserts deselects to honour minimum command spacing.
- Tracks per-bank open/closed state and rejects illegal commands before they reach the DRAM model.

---
 rtl/ddr4_ca_cmd_driver_pkg.sv | 36 +++
 rtl/ddr4_ca_cmd_driver_if.sv | 26 ++
 rtl/ddr4_ca_cmd_driver_bank_tracker.sv | 42 ++++
 rtl/ddr4_ca_cmd_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_ca_cmd_driver_pkg.sv
// Shared command definitions for the DDR4 command/address driver:
// command enum, per-command RAS/CAS/WE encodings, address bit positions
// and bank-array sizing.
package ddr4_cmd_pkg;

    // Bank addressing widths (same values as the architecture package).
    localparam int unsigned MAX_BANK_GROUP_BITS = 2;
    localparam int unsigned MAX_BANK_BITS       = 2;
    localparam int unsigned BANK_IDX_BITS       = MAX_BANK_GROUP_BITS + MAX_BANK_BITS;
    localparam int unsigned NUM_BANKS           = 2 ** BANK_IDX_BITS;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6
    } cmd_t;

    // {RAS_n, CAS_n, WE_n} for the non-ACT commands.
    localparam logic [2:0] RCW_MRS = 3'b000;
    localparam logic [2:0] RCW_REF = 3'b001;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_RD  = 3'b101;

    localparam int unsigned ADDR_BL8_BIT = 12;
    localparam int unsigned ADDR_AP_BIT  = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_ca_cmd_driver_if.sv
// Abstract DRAM command request channel (valid/ready) plus the
// illegal-command error pulse returned to the requester.
interface ddr4_ca_cmd_driver_if
    import ddr4_cmd_pkg::*;
;
    logic                           cmd_valid;
    logic                           cmd_ready;
    cmd_t                           cmd_type;
    logic [MAX_BANK_GROUP_BITS-1:0] cmd_bg;
    logic [MAX_BANK_BITS-1:0]       cmd_ba;
    logic [17:0]                    cmd_row;
    logic [9:0]                     cmd_col;
    logic                           cmd_ap;
    logic                           cmd_err;

    modport master (
        output cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_ap,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_ap,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/ddr4_ca_cmd_driver_bank_tracker.sv
// Open-bank bitmap: one bit per {bg,ba}. Reports whether the addressed
// bank is open and whether any bank is open.
module ddr4_bank_tracker
    import ddr4_cmd_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [BANK_IDX_BITS-1:0] idx_i,
    input  logic                     open_i,
    input  logic                     close_i,
    input  logic                     close_all_i,
    output logic                     bank_is_open_o,
    output logic                     any_open_o
);

    logic [NUM_BANKS-1:0] open_q, open_d;

    // Next bitmap: close-all wins, then single close, then open.
    always_comb begin
        open_d = open_q;
        if (close_all_i) begin
            open_d = '0;
        end else if (close_i) begin
            open_d[idx_i] = 1'b0;
        end else if (open_i) begin
            open_d[idx_i] = 1'b1;
        end
    end

    // Bitmap register, all banks closed out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q <= '0;
        end else begin
            open_q <= open_d;
        end
    end

    assign bank_is_open_o = open_q[idx_i];
    assign any_open_o     = |open_q;

endmodule

// File: rtl/ddr4_ca_cmd_driver.sv
// DDR4 command/address driver: accepts abstract commands, checks bank
// legality, encodes legal commands onto registered CA pins one cycle after
// acceptance and holds off the requester for the command's minimum spacing.
// Optional macro DDR4_CA_PARITY_EN enables the registered CA parity pin.
module ddr4_ca_cmd_driver
    import ddr4_cmd_pkg::*;
#(
    parameter int unsigned T_RCD       = 16,
    parameter int unsigned T_RP        = 16,
    parameter int unsigned T_CCD       = 4,
    parameter int unsigned T_RFC       = 260,
    parameter int unsigned T_MOD       = 24,
    parameter int unsigned INIT_CYCLES = 8
) (
    input  logic                           CK_t,
    input  logic                           RESET_n,
    ddr4_ca_cmd_driver_if.slave            cmd,
    output logic                           CKE,
    output logic                           CS_n,
    output logic                           ACT_n,
    output logic                           RAS_n_A16,
    output logic                           CAS_n_A15,
    output logic                           WE_n_A14,
    output logic [MAX_BANK_GROUP_BITS-1:0] BG,
    output logic [MAX_BANK_BITS-1:0]       BA,
    output logic [13:0]                    ADDR,
    output logic                           ADDR_17,
    output logic                           PARITY
);

    localparam int unsigned MAX_GAP = max_u(max_u(T_RCD, T_RP), max_u(max_u(T_CCD, T_RFC), T_MOD));
    localparam int unsigned WAIT_W  = $clog2(MAX_GAP + 1);
    localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t                         state_q;
    logic [INIT_W-1:0]              init_cnt_q;
    logic [WAIT_W-1:0]              wait_q;
    logic                           ready_q, err_q, cke_q, cs_n_q;
    logic                           act_n_q, ras_q, cas_q, we_q, a17_q;
    logic [MAX_BANK_GROUP_BITS-1:0] bg_q;
    logic [MAX_BANK_BITS-1:0]       ba_q;
    logic [13:0]                    addr_q;

    logic [BANK_IDX_BITS-1:0]       bank_idx;
    logic                           bank_open, any_open;
    logic                           legal, is_issue_type, accept, issue, drop;
    int unsigned                    gap;
    logic                           enc_act_n, enc_a17;
    logic [2:0]                     enc_rcw;
    logic [13:0]                    enc_addr;

    assign bank_idx = {cmd.cmd_bg, cmd.cmd_ba};

    // Legality check, spacing and pin encoding of the presented command.
    always_comb begin
        legal         = 1'b1;
        is_issue_type = 1'b1;
        gap           = 1;
        enc_act_n     = 1'b1;
        enc_rcw       = '0;
        enc_addr      = '0;
        enc_a17       = 1'b0;
        case (cmd.cmd_type)
            CMD_ACT: begin
                legal     = !bank_open;
                gap       = T_RCD;
                enc_act_n = 1'b0;
                enc_rcw   = cmd.cmd_row[16:14];
                enc_addr  = cmd.cmd_row[13:0];
                enc_a17   = cmd.cmd_row[17];
            end
            CMD_RD, CMD_WR: begin
                legal                  = bank_open;
                gap                    = cmd.cmd_ap ? max_u(T_CCD, T_RP) : T_CCD;
                enc_rcw                = (cmd.cmd_type == CMD_RD) ? RCW_RD : RCW_WR;
                enc_addr[9:0]          = cmd.cmd_col;
                enc_addr[ADDR_AP_BIT]  = cmd.cmd_ap;
                enc_addr[ADDR_BL8_BIT] = 1'b1;
            end
            CMD_PRE: begin
                gap                   = T_RP;
                enc_rcw               = RCW_PRE;
                enc_addr[ADDR_AP_BIT] = cmd.cmd_ap;
            end
            CMD_REF: begin
                legal   = !any_open;
                gap     = T_RFC;
                enc_rcw = RCW_REF;
            end
            CMD_MRS: begin
                legal    = !any_open;
                gap      = T_MOD;
                enc_rcw  = RCW_MRS;
                enc_addr = cmd.cmd_row[13:0];
            end
            default: is_issue_type = 1'b0;
        endcase
    end

    assign accept = cmd.cmd_valid && ready_q;
    assign issue  = accept && is_issue_type && legal;
    assign drop   = accept && is_issue_type && !legal;

    ddr4_bank_tracker u_bank_tracker (
        .clk_i          (CK_t),
        .rst_ni         (RESET_n),
        .idx_i          (bank_idx),
        .open_i         (issue && (cmd.cmd_type == CMD_ACT)),
        .close_i        (issue && (((cmd.cmd_type == CMD_PRE) && !cmd.cmd_ap) ||
                                   (((cmd.cmd_type == CMD_RD) || (cmd.cmd_type == CMD_WR)) && cmd.cmd_ap))),
        .close_all_i    (issue && (cmd.cmd_type == CMD_PRE) && cmd.cmd_ap),
        .bank_is_open_o (bank_open),
        .any_open_o     (any_open)
    );

`ifdef DDR4_CA_PARITY_EN
    logic parity_q;
    assign PARITY = parity_q;
`else
    assign PARITY = 1'b0;
`endif

    // Sequencer plus registered CA pins; pins other than CS_n hold across deselects.
    always_ff @(posedge CK_t or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            cke_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            act_n_q    <= 1'b1;
            ras_q      <= 1'b1;
            cas_q      <= 1'b1;
            we_q       <= 1'b1;
            bg_q       <= '0;
            ba_q       <= '0;
            addr_q     <= '0;
            a17_q      <= 1'b0;
`ifdef DDR4_CA_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            cs_n_q <= 1'b1;
            err_q  <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                        cke_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        cs_n_q  <= 1'b0;
                        act_n_q <= enc_act_n;
                        {ras_q, cas_q, we_q} <= enc_rcw;
                        bg_q    <= cmd.cmd_bg;
                        ba_q    <= cmd.cmd_ba;
                        addr_q  <= enc_addr;
                        a17_q   <= enc_a17;
`ifdef DDR4_CA_PARITY_EN
                        parity_q <= ^{enc_act_n, enc_rcw, cmd.cmd_bg, cmd.cmd_ba, enc_addr, enc_a17};
`endif
                        if (gap > 1) begin
                            ready_q <= 1'b0;
                            wait_q  <= WAIT_W'(gap - 1);
                            state_q <= ST_WAIT;
                        end
                    end
                    if (drop) begin
                        err_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_W'(1)) begin
                        wait_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.cmd_err   = err_q;
    assign CKE           = cke_q;
    assign CS_n          = cs_n_q;
    assign ACT_n         = act_n_q;
    assign RAS_n_A16     = ras_q;
    assign CAS_n_A15     = cas_q;
    assign WE_n_A14      = we_q;
    assign BG            = bg_q;
    assign BA            = ba_q;
    assign ADDR          = addr_q;
    assign ADDR_17       = a17_q;

endmodule
